mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares the single mem_ctrl front-end (cmd_n/RDnWR/Addr_in/Data_in handshake) between NUM_REQ requesters.
- Each accepted request is sequenced through issue, data and completion phases, and the completion is routed back to the owning requester.
- Arbitration is round-robin with bounded open-row preference, which cuts mem_ctrl PRE/ACT turnarounds.
- Sits between the client ports (DMA, CPU, test agents) and mem_ctrl.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CMD_HOLD, 2, cycles cmd_n is held low per request.
- WR_HOLD, 6, cycles Data_in_vld is held high after issue for a write.
- RD_TIMEOUT, 64, cycles to wait for data_out_vld before an error completion.
- MAX_BYPASS, 3, maximum consecutive row-hit grants that override the round-robin choice.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- req_rdnwr  in  NUM_REQ  1 = read, 0 = write, per requester.
- req_addr  in  NUM_REQ*16  flattened addresses; slice i is [16*i+15:16*i].
- req_wdata  in  NUM_REQ*32  flattened write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner.
- rsp_err  out  1  completion was a read timeout; valid with rsp_valid.
- rsp_rdata  out  32  read data; valid with rsp_valid for reads.
- cmd_n  out  1  to mem_ctrl, active-low command strobe.
- RDnWR  out  1  to mem_ctrl.
- Addr_in  out  16  to mem_ctrl.
- Data_in_vld  out  1  to mem_ctrl.
- Data_in  out  32  to mem_ctrl.
- Data_out  in  32  from mem_ctrl.
- data_out_vld  in  1  from mem_ctrl.

Behaviour:
- Reset values:
  - State IDLE.
  - cmd_n=1; RDnWR=0; Addr_in=0; Data_in=0; Data_in_vld=0.
  - req_ready=0; rsp_valid=0; rsp_err=0; rsp_rdata=0.
  - rr_ptr=0; last_row_vld=0; bypass_cnt=0; all counters 0.
- Reset mid-transaction: abandons the transaction without a completion. Requesters must re-present.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP.
- IDLE, with any req_valid set:
  - Compute the winner (arbitration rules below).
  - Latch the winner's rdnwr/addr/wdata and its index g.
  - Pulse req_ready[g] for exactly one cycle; go to ISSUE.
  - The requester must drop or advance req_valid on the cycle after req_ready.
- ISSUE:
  - cmd_n=0, RDnWR=latched rdnwr, Addr_in=latched addr, Data_in=latched wdata, held for CMD_HOLD cycles.
  - Data_in_vld=1 from the first ISSUE cycle if the request is a write.
  - Then go to WAIT_RD for a read, WAIT_WR for a write. cmd_n returns to 1.
- WAIT_RD:
  - Address stays stable.
  - On the first data_out_vld=1: capture Data_out into rsp_rdata, rsp_err=0, go to RESP.
  - If no data_out_vld after RD_TIMEOUT cycles (counted from WAIT_RD entry): rsp_rdata=0, rsp_err=1, go to RESP.
  - data_out_vld in any other state is ignored.
- WAIT_WR: Data_in_vld stays 1 until WR_HOLD total cycles since issue, then drops to 0; go to RESP.
- RESP:
  - rsp_valid[g]=1 for one cycle; rsp_err reflects the outcome.
  - Update last_row=addr[15:12] and last_row_vld=1.
  - Return to IDLE. The next grant occurs no earlier than the cycle after RESP.
- Arbitration (combinational, evaluated in IDLE only):
  - hit[i] = req_valid[i] & last_row_vld & (addr_i[15:12]==last_row).
  - If hit is nonzero and bypass_cnt<MAX_BYPASS: winner = first set bit of hit, searching from rr_ptr upward with wrap.
  - Otherwise: winner = first set bit of req_valid, searching from rr_ptr with wrap.
  - bypass_cnt increments when the hit winner differs from the plain round-robin winner; it resets to 0 otherwise.
  - rr_ptr becomes (winner+1) mod NUM_REQ on every grant.
- Starvation bound: any valid requester is granted within NUM_REQ*(MAX_BYPASS+1) grants.
- Counters saturate and never wrap. The index wrap NUM_REQ-1 -> 0 is required.
- Single requester: granted back-to-back, one transaction per FSM loop. No pipelining; at most one outstanding transaction.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum.
  - Row field constants ROW_MSB=15, ROW_LSB=12.
  - Defaults for CMD_HOLD, WR_HOLD and RD_TIMEOUT.
- Sub-module mem_arb_rr_pick: parameterized rotating-priority encoder (mask in, start pointer in, one-hot and index out, any-valid out). It is instantiated twice, once for the hit mask and once for the valid mask.

Test Plan:
- Single read: req_valid=0001, rdnwr=1, addr=16'h3010; mem_ctrl model returns data_out_vld with 32'hDEADBEEF -> cmd_n low 2 cycles, Addr_in=16'h3010, rsp_valid=0001, rsp_rdata=DEADBEEF, rsp_err=0.
- Round robin: all 4 requesters valid, distinct rows 0..3, no hits -> grant order 0,1,2,3,0; exactly one req_ready pulse per grant.
- Row-hit bypass: last_row=5, req0 row 1, req2 row 5 continuously re-requesting -> req2 wins 3 times, then req0 is granted (bypass_cnt cap = 3).
- Write: req1 writes 32'hA5A5_0001 to 16'h0FFF -> Data_in_vld high exactly 6 cycles from the first ISSUE cycle, Data_in stable, rsp_valid=0010, rsp_err=0.
- Timeout: read with no data_out_vld -> after 64 WAIT_RD cycles rsp_valid pulses with rsp_err=1 and rsp_rdata=0; the next requester is then granted normally.
- Reset mid-WAIT_WR: rst_n low for 1 cycle -> all outputs return to reset values immediately, no rsp_valid, rr_ptr=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_ctrl request arbiter.
// Row field extraction is kept here so the hit compare and the row tracker agree.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

  localparam int AW             = 16;
  localparam int DW             = 32;
  localparam int ROW_MSB        = 15;
  localparam int ROW_LSB        = 12;
  localparam int ROW_W          = ROW_MSB - ROW_LSB + 1;
  localparam int CMD_HOLD_DEF   = 2;
  localparam int WR_HOLD_DEF    = 6;
  localparam int RD_TIMEOUT_DEF = 64;

  function automatic logic [ROW_W-1:0] row_of(input logic [AW-1:0] addr);
    return addr[ROW_MSB:ROW_LSB];
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotating-priority encoder: first set bit of mask at or above start, wrapping.
// Reports the winner as one-hot and as an index, plus whether any bit was set.
module mem_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int   pos_s;
  logic take_s;

  // Scan N positions from start; only the first set bit is taken
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos_s  = 0;
    take_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s  = (int'(start) + k >= N) ? (int'(start) + k - N) : (int'(start) + k);
      take_s = !any && mask[IW'(pos_s)];
      onehot[IW'(pos_s)] = onehot[IW'(pos_s)] | take_s;
      idx    = take_s ? IW'(pos_s) : idx;
      any    = any | take_s;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the mem_ctrl command front-end between NUM_REQ requesters using
// round-robin arbitration with a bounded open-row preference.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CMD_HOLD   = CMD_HOLD_DEF,
  parameter int WR_HOLD    = WR_HOLD_DEF,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF,
  parameter int MAX_BYPASS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_rdnwr,
  input  logic [NUM_REQ*16-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  cmd_n,
  output logic                  RDnWR,
  output logic [15:0]           Addr_in,
  output logic                  Data_in_vld,
  output logic [31:0]           Data_in,
  input  logic [31:0]           Data_out,
  input  logic                  data_out_vld
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (RD_TIMEOUT > WR_HOLD) ? RD_TIMEOUT : WR_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(MAX_BYPASS + 2);

  arb_state_t          state_r, state_s;
  logic                cmd_n_r, rdnwr_r, din_vld_r, rsp_err_r, last_row_vld_r;
  logic [AW-1:0]       addr_r;
  logic [DW-1:0]       wdata_r, rsp_rdata_r;
  logic [NUM_REQ-1:0]  req_ready_r, rsp_valid_r, owner_r;
  logic [CW-1:0]       cnt_r, cnt_inc_s;
  logic [IW-1:0]       rr_ptr_r, rr_next_s;
  logic [BW-1:0]       bypass_cnt_r, bypass_next_s;
  logic [ROW_W-1:0]    last_row_r;

  logic [NUM_REQ-1:0]  hit_s, rr_onehot_s, hit_onehot_s, win_onehot_s;
  logic [IW-1:0]       rr_idx_s, hit_idx_s, win_idx_s;
  logic                rr_any_s, hit_any_s, use_hit_s;
  logic                grant_s, issue_done_s, rd_done_s, rd_tmo_s, wr_done_s;

  // Row-hit mask against the row left open by the previous completion
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_s[i] = req_valid[i] & last_row_vld_r &
                 (row_of(req_addr[i*AW +: AW]) == last_row_r);
    end
  end

  mem_arb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_rr (
    .mask(req_valid), .start(rr_ptr_r), .onehot(rr_onehot_s), .idx(rr_idx_s), .any(rr_any_s)
  );

  mem_arb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_hit (
    .mask(hit_s), .start(rr_ptr_r), .onehot(hit_onehot_s), .idx(hit_idx_s), .any(hit_any_s)
  );

  // Winner selection; the bypass counter only grows while a hit overrides round-robin
  always_comb begin
    use_hit_s     = hit_any_s && (bypass_cnt_r < BW'(MAX_BYPASS));
    win_idx_s     = use_hit_s ? hit_idx_s : rr_idx_s;
    win_onehot_s  = use_hit_s ? hit_onehot_s : rr_onehot_s;
    rr_next_s     = (win_idx_s == IW'(NUM_REQ - 1)) ? '0 : win_idx_s + IW'(1);
    bypass_next_s = (use_hit_s && (hit_idx_s != rr_idx_s)) ? bypass_cnt_r + BW'(1) : '0;
    cnt_inc_s     = (cnt_r == '1) ? cnt_r : cnt_r + CW'(1);
  end

  // Next-state logic and transition strobes
  always_comb begin
    state_s      = state_r;
    grant_s      = 1'b0;
    issue_done_s = 1'b0;
    rd_done_s    = 1'b0;
    rd_tmo_s     = 1'b0;
    wr_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rr_any_s) begin
          grant_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_r >= CW'(CMD_HOLD - 1)) begin
          issue_done_s = 1'b1;
          state_s      = rdnwr_r ? WAIT_RD : WAIT_WR;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_RD: begin
        if (data_out_vld) begin
          rd_done_s = 1'b1;
          state_s   = RESP;
        end else if (cnt_r >= CW'(RD_TIMEOUT - 1)) begin
          rd_tmo_s = 1'b1;
          state_s  = RESP;
        end else begin
          state_s = WAIT_RD;
        end
      end
      WAIT_WR: begin
        if (cnt_r >= CW'(WR_HOLD - 1)) begin
          wr_done_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = WAIT_WR;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Registered outputs, latched request and arbitration history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_n_r        <= 1'b1;
      rdnwr_r        <= 1'b0;
      addr_r         <= '0;
      wdata_r        <= '0;
      din_vld_r      <= 1'b0;
      req_ready_r    <= '0;
      rsp_valid_r    <= '0;
      rsp_err_r      <= 1'b0;
      rsp_rdata_r    <= '0;
      owner_r        <= '0;
      cnt_r          <= '0;
      rr_ptr_r       <= '0;
      bypass_cnt_r   <= '0;
      last_row_r     <= '0;
      last_row_vld_r <= 1'b0;
    end else begin
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (grant_s) begin
            req_ready_r  <= win_onehot_s;
            owner_r      <= win_onehot_s;
            cmd_n_r      <= 1'b0;
            rdnwr_r      <= req_rdnwr[win_idx_s];
            addr_r       <= req_addr[int'(win_idx_s)*AW +: AW];
            wdata_r      <= req_wdata[int'(win_idx_s)*DW +: DW];
            din_vld_r    <= ~req_rdnwr[win_idx_s];
            rr_ptr_r     <= rr_next_s;
            bypass_cnt_r <= bypass_next_s;
          end else begin
            cmd_n_r <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_done_s) begin
            cmd_n_r <= 1'b1;
            cnt_r   <= rdnwr_r ? '0 : cnt_inc_s;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        WAIT_RD: begin
          if (rd_done_s) begin
            rsp_rdata_r <= Data_out;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= owner_r;
          end else if (rd_tmo_s) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= owner_r;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        WAIT_WR: begin
          if (wr_done_s) begin
            din_vld_r   <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= owner_r;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        RESP: begin
          last_row_r     <= row_of(addr_r);
          last_row_vld_r <= 1'b1;
        end
        default: cmd_n_r <= 1'b1;
      endcase
    end
  end

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign cmd_n       = cmd_n_r;
  assign RDnWR       = rdnwr_r;
  assign Addr_in     = addr_r;
  assign Data_in_vld = din_vld_r;
  assign Data_in     = wdata_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a small mem_ctrl read responder.
// Sampling and input driving both happen on the falling clock edge.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, req_rdnwr, rsp_valid;
  logic [63:0] req_addr;
  logic [127:0] req_wdata;
  logic        rsp_err, cmd_n, RDnWR, Data_in_vld, data_out_vld;
  logic [31:0] rsp_rdata, Data_in, Data_out;
  logic [15:0] Addr_in;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mem_en   = 1'b0;
  logic [31:0] mem_data = 32'h0;
  int   mem_dly;
  logic prev_cmd_n;

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rdnwr(req_rdnwr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cmd_n(cmd_n), .RDnWR(RDnWR), .Addr_in(Addr_in), .Data_in_vld(Data_in_vld),
    .Data_in(Data_in), .Data_out(Data_out), .data_out_vld(data_out_vld)
  );

  // mem_ctrl stand-in: answers a read 3 cycles after the command strobe falls
  initial begin
    data_out_vld = 1'b0;
    Data_out     = 32'h0;
    prev_cmd_n   = 1'b1;
    mem_dly      = 0;
    forever begin
      @(negedge clk);
      data_out_vld = 1'b0;
      if (mem_dly > 0) begin
        mem_dly--;
        if (mem_dly == 0) begin
          data_out_vld = 1'b1;
          Data_out     = mem_data;
        end
      end
      if (mem_en && prev_cmd_n === 1'b1 && cmd_n === 1'b0 && RDnWR === 1'b1) mem_dly = 3;
      prev_cmd_n = cmd_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_grant(output logic [3:0] g, output int cyc);
    cyc = 0;
    while (req_ready === 4'b0000 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    g = req_ready;
  endtask

  task automatic wait_rsp(output logic [3:0] r, output int cyc);
    cyc = 0;
    while (rsp_valid === 4'b0000 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    r = rsp_valid;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_n !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_n: got %b exp 1", cmd_n); end
    n_checks++; if (RDnWR !== 1'b0) begin n_fail++; $display("FAIL rst_rdnwr: got %b exp 0", RDnWR); end
    n_checks++; if (Addr_in !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h exp 0000", Addr_in); end
    n_checks++; if (Data_in !== 32'h0 || Data_in_vld !== 1'b0) begin n_fail++; $display("FAIL rst_data: got %h/%b exp 0/0", Data_in, Data_in_vld); end
    n_checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_hs: got %b/%b exp 0000/0000", req_ready, rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp: got %b/%h exp 0/0", rsp_err, rsp_rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_n !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_quiet: got %b/%b exp 1/0000", cmd_n, req_ready); end
  endtask

  task automatic test_single_read();
    logic [3:0] g, r;
    int c, n;
    mem_en = 1'b1;
    mem_data = 32'hDEADBEEF;
    req_rdnwr[0] = 1'b1;
    req_addr[15:0] = 16'h3010;
    req_valid = 4'b0001;
    wait_grant(g, c);
    req_valid = 4'b0000;
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL rd_grant: got %b exp 0001", g); end
    n_checks++; if (Addr_in !== 16'h3010 || RDnWR !== 1'b1) begin n_fail++; $display("FAIL rd_cmd: got %h/%b exp 3010/1", Addr_in, RDnWR); end
    n = 0;
    while (cmd_n === 1'b0 && n < 10) begin n++; @(negedge clk); end
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL rd_cmd_len: got %0d exp 2", n); end
    n_checks++; if (Addr_in !== 16'h3010) begin n_fail++; $display("FAIL rd_addr_hold: got %h exp 3010", Addr_in); end
    wait_rsp(r, c);
    n_checks++; if (r !== 4'b0001) begin n_fail++; $display("FAIL rd_rsp: got %b exp 0001", r); end
    n_checks++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_data: got %h/%b exp deadbeef/0", rsp_rdata, rsp_err); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rd_rsp_pulse: got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_timeout();
    logic [3:0] g, r;
    int c;
    mem_en = 1'b0;
    req_rdnwr[0] = 1'b1;
    req_addr[15:0] = 16'h1234;
    req_valid = 4'b0001;
    wait_grant(g, c);
    req_valid = 4'b0000;
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL to_grant: got %b exp 0001", g); end
    wait_rsp(r, c);
    n_checks++; if (c !== 66) begin n_fail++; $display("FAIL to_latency: got %0d exp 66", c); end
    n_checks++; if (r !== 4'b0001 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_rsp: got %b/%b exp 0001/1", r, rsp_err); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h exp 0", rsp_rdata); end
    req_rdnwr[1] = 1'b0;
    req_addr[31:16] = 16'h2000;
    req_wdata[63:32] = 32'h1111_2222;
    req_valid = 4'b0010;
    wait_grant(g, c);
    req_valid = 4'b0000;
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL to_next_grant: got %b exp 0010", g); end
    wait_rsp(r, c);
    n_checks++; if (r !== 4'b0010 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL to_next_rsp: got %b/%b exp 0010/0", r, rsp_err); end
  endtask

  task automatic test_write();
    logic [3:0] g, r;
    int c, n;
    bit bad;
    req_rdnwr[1] = 1'b0;
    req_addr[31:16] = 16'h0FFF;
    req_wdata[63:32] = 32'hA5A5_0001;
    req_valid = 4'b0010;
    wait_grant(g, c);
    req_valid = 4'b0000;
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL wr_grant: got %b exp 0010", g); end
    n_checks++; if (RDnWR !== 1'b0 || Addr_in !== 16'h0FFF) begin n_fail++; $display("FAIL wr_cmd: got %b/%h exp 0/0fff", RDnWR, Addr_in); end
    n = 0;
    bad = 1'b0;
    while (Data_in_vld === 1'b1 && n < 20) begin
      n++;
      if (Data_in !== 32'hA5A5_0001) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (n !== 6) begin n_fail++; $display("FAIL wr_vld_len: got %0d exp 6", n); end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL wr_data_stable: got unstable exp a5a50001"); end
    wait_rsp(r, c);
    n_checks++; if (r !== 4'b0010 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got %b/%b exp 0010/0", r, rsp_err); end
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] g, r;
    int c, n;
    req_rdnwr[1] = 1'b0;
    req_addr[31:16] = 16'h4000;
    req_valid = 4'b0010;
    wait_grant(g, c);
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    n_checks++; if (Data_in_vld !== 1'b1) begin n_fail++; $display("FAIL mr_pre_vld: got %b exp 1", Data_in_vld); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (cmd_n !== 1'b1 || Data_in_vld !== 1'b0 || RDnWR !== 1'b0) begin n_fail++; $display("FAIL mr_ctrl: got %b/%b/%b exp 1/0/0", cmd_n, Data_in_vld, RDnWR); end
    n_checks++; if (Addr_in !== 16'h0 || Data_in !== 32'h0) begin n_fail++; $display("FAIL mr_bus: got %h/%h exp 0/0", Addr_in, Data_in); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) n++;
    end
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL mr_no_rsp: got %0d pulses exp 0", n); end
    req_rdnwr = 4'b0000;
    req_addr = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
    req_valid = 4'b1111;
    wait_grant(g, c);
    req_valid = 4'b0000;
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL mr_rr_ptr: got %b exp 0001", g); end
    wait_rsp(r, c);
  endtask

  task automatic test_round_robin();
    logic [3:0] g, r, exp_g;
    int c;
    apply_reset();
    req_rdnwr = 4'b0000;
    req_addr = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      wait_grant(g, c);
      req_valid = (k == 3) ? 4'b0111 : (req_valid & ~g);
      n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", k, g, exp_g); end
      @(negedge clk);
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_pulse%0d: got %b exp 0000", k, req_ready); end
    end
    wait_grant(g, c);
    req_valid = 4'b0000;
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap: got %b exp 0001", g); end
    wait_rsp(r, c);
  endtask

  task automatic test_bypass();
    logic [3:0] g, r, exp_g;
    int c;
    apply_reset();
    mem_en = 1'b1;
    mem_data = 32'h0BAD_F00D;
    req_rdnwr = 4'b0101;
    req_addr = {16'h0000, 16'h5000, 16'h0000, 16'h1000};
    req_valid = 4'b0100;
    wait_grant(g, c);
    n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL bp_setup: got %b exp 0100", g); end
    wait_rsp(r, c);
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k < 3) ? 4'b0100 : 4'b0001;
      wait_grant(g, c);
      if (k == 3) req_valid = 4'b0000;
      n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL bp_grant%0d: got %b exp %b", k, g, exp_g); end
      @(negedge clk);
    end
    wait_rsp(r, c);
    n_checks++; if (r !== 4'b0001 || rsp_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL bp_rsp: got %b/%h exp 0001/0badf00d", r, rsp_rdata); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b0000;
    req_rdnwr = 4'b0000;
    req_addr = 64'h0;
    req_wdata = 128'h0;
    test_reset();
    test_single_read();
    test_timeout();
    test_write();
    test_reset_mid_write();
    test_round_robin();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
